ro_array_freq_monitor: RTL and testbench

//  Array of NUM_CH gated ring oscillators plus a clk-domain frequency counter.

---
 rtl/ro_array_freq_monitor.sv | 180 ++++++++++++++++++
 tb/tb_ro_array_freq_monitor.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_array_freq_monitor.sv
// Ring-oscillator array with a clk-domain frequency counter.
// One ring at a time is enabled, allowed to settle, then its rising edges are
// counted over a fixed window. Results are published with a sticky per-channel
// low-frequency alarm. Supports single-shot and round-robin scans.
module ro_array_freq_monitor #(
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned NUM_STAGES    = 7,
   parameter int unsigned CH_W          = 2,
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned WINDOW_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              scan_mode,
   input  logic [CH_W-1:0]   ch_sel,
   input  logic              abort,
   input  logic [CNT_W-1:0]  min_count,
   input  logic              alarm_clr,
   output logic              busy,
   output logic              result_valid,
   output logic [CH_W-1:0]   result_ch,
   output logic [CNT_W-1:0]  result_count,
   output logic [NUM_CH-1:0] alarm,
   output logic              osc_mon
);
   timeunit 1ns;
   timeprecision 1ps;

   localparam int unsigned TMR_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES
                                                                     : WINDOW_CYCLES;
   localparam int unsigned TMR_W = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0]  WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
   localparam logic [CH_W-1:0]   CH_LAST     = CH_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
   localparam logic [NUM_CH-1:0] ONE_HOT0    = NUM_CH'(1);

   typedef enum logic [1:0] {StIdle, StSettle, StCount, StDone} state_e;

   state_e             state_q, state_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic               mode_q, mode_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CH_W-1:0]    res_ch_q, res_ch_d;
   logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
   logic [NUM_CH-1:0]  alarm_q, alarm_d;
   logic [2:0]         sync_q;
   logic [NUM_CH-1:0]  en;
   logic               edge_pulse;
   wire  [NUM_CH-1:0]  ring_tap;

   // Gated rings: node[0] = en & last node, then an odd inverter chain.
   // The per-inverter delay only shapes simulation; synthesis ignores it.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ring
      wire [NUM_STAGES:0] node;
      assign node[0] = en[c] & node[NUM_STAGES];
      for (genvar s = 0; s < NUM_STAGES; s++) begin : g_inv
         assign #1 node[s+1] = ~node[s];
      end
      assign ring_tap[c] = node[NUM_STAGES];
   end

   // A disabled ring idles high at its tap, so gate it to report 0.
   assign osc_mon = |(en & ring_tap);

   // Two-flop synchroniser plus a history flop for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], osc_mon};
      end
   end

   assign edge_pulse = sync_q[1] & ~sync_q[2];

   // Next-state, ring enable, counter and result/alarm update.
   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      mode_d    = mode_q;
      tmr_d     = tmr_q;
      cnt_d     = cnt_q;
      res_ch_d  = res_ch_q;
      res_cnt_d = res_cnt_q;
      alarm_d   = alarm_clr ? '0 : alarm_q;
      en        = '0;

      unique case (state_q)
         StIdle: begin
            if (start && !abort) begin
               state_d = StSettle;
               ch_d    = (32'(ch_sel) >= NUM_CH) ? '0 : ch_sel;
               mode_d  = scan_mode;
               tmr_d   = '0;
               cnt_d   = '0;
            end
         end
         StSettle: begin
            en    = ONE_HOT0 << ch_q;
            cnt_d = '0;
            if (abort) begin
               state_d = StIdle;
            end else if (tmr_q == SETTLE_LAST) begin
               state_d = StCount;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         StCount: begin
            en = ONE_HOT0 << ch_q;
            if (edge_pulse && (cnt_q != CNT_MAX)) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (abort) begin
               state_d = StIdle;
            end else if (tmr_q == WINDOW_LAST) begin
               // Results are loaded on entry to DONE so they are visible with result_valid.
               state_d   = StDone;
               tmr_d     = '0;
               res_ch_d  = ch_q;
               res_cnt_d = cnt_d;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         StDone: begin
            if (abort) begin
               state_d = StIdle;
            end else begin
               // Applied after the clear so a same-cycle set wins for this bit.
               if (cnt_q < min_count) begin
                  alarm_d = alarm_d | (ONE_HOT0 << ch_q);
               end
               if (mode_q && scan_mode) begin
                  ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                  state_d = StSettle;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         ch_q      <= '0;
         mode_q    <= 1'b0;
         tmr_q     <= '0;
         cnt_q     <= '0;
         res_ch_q  <= '0;
         res_cnt_q <= '0;
         alarm_q   <= '0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         mode_q    <= mode_d;
         tmr_q     <= tmr_d;
         cnt_q     <= cnt_d;
         res_ch_q  <= res_ch_d;
         res_cnt_q <= res_cnt_d;
         alarm_q   <= alarm_d;
      end
   end

   assign busy         = (state_q != StIdle);
   assign result_valid = (state_q == StDone);
   assign result_ch    = res_ch_q;
   assign result_count = res_cnt_q;
   assign alarm        = alarm_q;

endmodule

// File: tb/tb_ro_array_freq_monitor.sv
// Bench for ro_array_freq_monitor: directed scenarios plus randomized traffic,
// checked every cycle against a measurement-level reference model.
module tb_ro_array_freq_monitor;
   timeunit 1ns;
   timeprecision 1ps;

   localparam int unsigned NUM_CH     = 4;
   localparam int unsigned NUM_STAGES = 7;
   localparam int unsigned CH_W       = 2;
   localparam int unsigned CNT_W      = 16;
   localparam int unsigned SETTLE     = 8;
   localparam int unsigned WINDOW     = 64;
   // Cycles from the start request to the result_valid cycle.
   localparam int unsigned TOTAL      = 1 + SETTLE + WINDOW;
   // clk period 5ns, ring period 2*NUM_STAGES*1ns: rising edges in the window.
   localparam int unsigned BAND_LO    = (WINDOW * 5) / (2 * NUM_STAGES);
   localparam int unsigned BAND_HI    = BAND_LO + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic              scan_mode = 1'b0;
   logic [CH_W-1:0]   ch_sel = '0;
   logic              abort = 1'b0;
   logic [CNT_W-1:0]  min_count = '0;
   logic              alarm_clr = 1'b0;
   logic              busy, result_valid, osc_mon;
   logic [CH_W-1:0]   result_ch;
   logic [CNT_W-1:0]  result_count;
   logic [NUM_CH-1:0] alarm;

   // Second instance: narrow counter, long window, 3-bit channel select.
   logic       start2 = 1'b0;
   logic [2:0] ch_sel2 = '0;
   logic       busy2, rv2, osc2;
   logic [2:0] rch2;
   logic [3:0] rcnt2;
   logic [3:0] alarm2;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   // Reference model state (measurement level).
   bit                m_active = 1'b0;
   bit                m_mode = 1'b0;
   int                m_k = 0;
   int                m_ch = 0;
   int                m_res_ch = 0;
   int                m_res_lo = 0;
   int                m_res_hi = 0;
   logic [NUM_CH-1:0] m_alarm = '0;
   logic [NUM_CH-1:0] nxt_alarm;

   ro_array_freq_monitor #(
      .NUM_CH(NUM_CH), .NUM_STAGES(NUM_STAGES), .CH_W(CH_W), .CNT_W(CNT_W),
      .SETTLE_CYCLES(SETTLE), .WINDOW_CYCLES(WINDOW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .scan_mode(scan_mode), .ch_sel(ch_sel),
      .abort(abort), .min_count(min_count), .alarm_clr(alarm_clr), .busy(busy),
      .result_valid(result_valid), .result_ch(result_ch), .result_count(result_count),
      .alarm(alarm), .osc_mon(osc_mon)
   );

   ro_array_freq_monitor #(
      .NUM_CH(4), .NUM_STAGES(7), .CH_W(3), .CNT_W(4),
      .SETTLE_CYCLES(8), .WINDOW_CYCLES(200)
   ) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start2), .scan_mode(1'b0), .ch_sel(ch_sel2),
      .abort(1'b0), .min_count(4'd0), .alarm_clr(1'b0), .busy(busy2),
      .result_valid(rv2), .result_ch(rch2), .result_count(rcnt2),
      .alarm(alarm2), .osc_mon(osc2)
   );

   always #2.5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input longint act, input longint lo,
                              input longint hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int ch, input bit scan, output int t0);
      ch_sel    = CH_W'(ch);
      scan_mode = scan;
      start     = 1'b1;
      t0        = cyc;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output bit got, output int at);
      got = 1'b0;
      at  = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (result_valid) begin
            got = 1'b1;
            at  = cyc;
            break;
         end
      end
   endtask

   // Model: k counts cycles of the current measurement; k==TOTAL is the result cycle.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_active = 1'b0;
         m_mode   = 1'b0;
         m_k      = 0;
         m_ch     = 0;
         m_res_ch = 0;
         m_res_lo = 0;
         m_res_hi = 0;
         m_alarm  = '0;
      end else begin
         nxt_alarm = alarm_clr ? '0 : m_alarm;
         if (!m_active) begin
            if (start && !abort) begin
               m_active = 1'b1;
               m_ch     = (int'(ch_sel) < int'(NUM_CH)) ? int'(ch_sel) : 0;
               m_mode   = scan_mode;
               m_k      = 1;
            end
         end else if (abort) begin
            m_active = 1'b0;
         end else if (m_k == int'(TOTAL)) begin
            // min_count is never drawn from (BAND_LO, BAND_HI], so the outcome is certain.
            if (int'(min_count) > int'(BAND_HI)) nxt_alarm[m_ch] = 1'b1;
            if (m_mode && scan_mode) begin
               m_ch = (m_ch + 1) % int'(NUM_CH);
               m_k  = 1;
            end else begin
               m_active = 1'b0;
            end
         end else begin
            m_k++;
            if (m_k == int'(TOTAL)) begin
               m_res_ch = m_ch;
               m_res_lo = int'(BAND_LO);
               m_res_hi = int'(BAND_HI);
            end
         end
         m_alarm = nxt_alarm;
      end
   end

   // Every-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("busy", busy, m_active);
         check("result_valid", result_valid, m_active && (m_k == int'(TOTAL)));
         check("result_ch", result_ch, m_res_ch);
         check_range("result_count", result_count, m_res_lo, m_res_hi);
         check("alarm", alarm, m_alarm);
         if (!(m_active && m_k < int'(TOTAL))) check("osc_mon_off", osc_mon, 0);
      end
   end

   initial begin
      bit got;
      int at, t0;
      int order [6];
      order = '{3, 0, 1, 2, 3, 0};

      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("reset_busy", busy, 0);
      check("reset_result_count", result_count, 0);
      check("reset_alarm", alarm, 0);

      // Single shot on channel 2.
      pulse_start(2, 1'b0, t0);
      wait_valid(200, got, at);
      check("single_seen", got, 1);
      check("single_latency", at - t0, 73);
      check("single_ch", result_ch, 2);
      check_range("single_count", result_count, 22, 23);

      // Round-robin scan from channel 3, stopped during channel 1.
      tick();
      pulse_start(3, 1'b1, t0);
      for (int i = 0; i < 6; i++) begin
         wait_valid(200, got, at);
         check("scan_seen", got, 1);
         check("scan_order", result_ch, order[i]);
         check("scan_spacing", at - t0, 73);
         t0 = at;
      end
      tick();
      scan_mode = 1'b0;
      wait_valid(200, got, at);
      check("scan_stop_seen", got, 1);
      check("scan_stop_ch", result_ch, 1);
      tick();
      check("scan_stop_idle", busy, 0);
      wait_valid(100, got, at);
      check("scan_stop_no_more", got, 0);

      // Abort in the counting window of channel 1.
      pulse_start(1, 1'b0, t0);
      repeat (30) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_idle", busy, 0);
      wait_valid(100, got, at);
      check("abort_no_result", got, 0);
      check("abort_ch_kept", result_ch, 1);
      pulse_start(0, 1'b0, t0);
      wait_valid(200, got, at);
      check("after_abort_latency", at - t0, 73);
      check("after_abort_ch", result_ch, 0);

      // Alarm set and sticky; clear during DONE of channel 0.
      tick();
      min_count = 16'd30;
      pulse_start(2, 1'b0, t0);
      wait_valid(200, got, at);
      tick();
      check("alarm_ch2", alarm, 4'b0100);
      pulse_start(0, 1'b0, t0);
      wait_valid(200, got, at);
      check("alarm_clr_seen", got, 1);
      alarm_clr = 1'b1;
      tick();
      alarm_clr = 1'b0;
      check("alarm_clr_set_wins", alarm, 4'b0001);

      // Reset in the middle of a counting window.
      pulse_start(3, 1'b0, t0);
      repeat (20) tick();
      rst_n = 1'b0;
      #0.5;
      check("midreset_busy", busy, 0);
      check("midreset_count", result_count, 0);
      check("midreset_alarm", alarm, 0);
      check("midreset_osc", osc_mon, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Saturation, out-of-range channel, start while busy ignored.
      ch_sel2 = 3'd5;
      start2  = 1'b1;
      t0      = cyc;
      tick();
      start2  = 1'b0;
      repeat (20) tick();
      ch_sel2 = 3'd1;
      start2  = 1'b1;
      tick();
      start2  = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (rv2) begin
            got = 1'b1;
            at  = cyc;
            break;
         end
      end
      check("sat_seen", got, 1);
      check("sat_latency", at - t0, 209);
      check("sat_ch", rch2, 0);
      check("sat_count", rcnt2, 15);
      check("sat_alarm", alarm2, 0);
      tick();
      check("sat_busy_after", busy2, 0);
      check("sat_osc_after", osc2, 0);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         tick();
         start     = ($urandom_range(0, 9) == 0);
         abort     = ($urandom_range(0, 199) == 0);
         alarm_clr = ($urandom_range(0, 59) == 0);
         ch_sel    = CH_W'($urandom_range(0, NUM_CH - 1));
         if ($urandom_range(0, 99) == 0) scan_mode = ~scan_mode;
         if ($urandom_range(0, 149) == 0) begin
            if ($urandom_range(0, 1) == 0) min_count = CNT_W'($urandom_range(0, BAND_LO));
            else min_count = CNT_W'($urandom_range(BAND_HI + 1, BAND_HI + 40));
         end
      end
      start = 1'b0;
      abort = 1'b0;
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
